// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity mode constants, the
// baud divider calculation and the parity check helper. Intended to be
// shared by the receiver and a future transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // sysclk cycles per oversampling tick, rounded to nearest
  function automatic int calc_div(input longint clk_freq, input longint baud,
                                  input longint oversample);
    longint den;
    den = baud * oversample;
    return int'((clk_freq + den / 64'sd2) / den);
  endfunction

  // data_xor is the XOR of all data bits; returns 1 when the received parity
  // bit disagrees with the configured mode (never flags in PAR_NONE)
  function automatic logic parity_bad(input logic data_xor, input logic par_bit,
                                      input int mode);
    logic bad;
    case (mode)
      PAR_ODD:  bad = ~(data_xor ^ par_bit);
      PAR_EVEN: bad = data_xor ^ par_bit;
      default:  bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator.
//   sysclk  : system clock
//   reset   : asynchronous active-low reset
//   restart : synchronously zeroes the divider (start-edge alignment)
//   tick    : registered one-cycle pulse every DIV sysclk cycles
module uart_baud_tick #(
  parameter int DIV = 10
) (
  input  logic sysclk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_r;
  logic          tick_r;

  // free-running divider, realigned on restart
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else if (restart) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else if (cnt_r == CW'(DIV - 1)) begin
      cnt_r  <= '0;
      tick_r <= 1'b1;
    end else begin
      cnt_r  <= cnt_r + 1'b1;
      tick_r <= 1'b0;
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with majority-vote sampling, false-start
// rejection, error reporting and a valid/ready holding register.
//   sysclk      : system clock (rising edge)
//   reset       : asynchronous active-low reset
//   UART_RX     : asynchronous serial line, idles high
//   rx_data     : received word, stable while rx_valid
//   rx_valid    : word available, held until rx_valid & rx_ready
//   rx_ready    : consumer accept
//   err_frame   : one-cycle pulse, stop bit sampled low
//   err_parity  : one-cycle pulse, parity mismatch
//   err_overrun : one-cycle pulse, good frame arrived while word still held
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 UART_RX,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 err_frame,
  output logic                 err_parity,
  output logic                 err_overrun
);

  localparam int DIV = calc_div(longint'(CLK_FREQ), longint'(BAUD), longint'(OVERSAMPLE));
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS + 1);

  if (DIV < 2) begin : g_div_check
    $error("uart_rx_param: baud divider below 2");
  end

  logic                 sync1_r, sync2_r, sync3_r;
  logic                 fall_s, restart_s, tick_s, maj_s, decide_s, accept_s, par_bad_s;
  uart_state_t          state_r;
  logic [TW-1:0]        tick_cnt_r;
  logic [BW-1:0]        bit_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 samp0_r, samp1_r, par_bit_r;
  logic [DATA_BITS-1:0] rx_data_r;
  logic                 rx_valid_r, err_frame_r, err_parity_r, err_overrun_r;

  // two-flop synchroniser plus a delayed copy for edge detection
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      sync3_r <= 1'b1;
    end else begin
      sync1_r <= UART_RX;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
    end
  end

  assign fall_s    = sync3_r & ~sync2_r;
  assign restart_s = (state_r == ST_IDLE) & fall_s;
  assign accept_s  = rx_valid_r & rx_ready;
  // third sample is the live line; the first two were captured earlier
  assign maj_s     = (samp0_r & samp1_r) | (samp0_r & sync2_r) | (samp1_r & sync2_r);
  assign decide_s  = tick_s & (tick_cnt_r == TW'(OVERSAMPLE / 2 + 1));
  assign par_bad_s = parity_bad(^shift_r, par_bit_r, PARITY);

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .sysclk  (sysclk),
    .reset   (reset),
    .restart (restart_s),
    .tick    (tick_s)
  );

  // receive state machine and registered outputs
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      tick_cnt_r    <= '0;
      bit_cnt_r     <= '0;
      shift_r       <= '0;
      samp0_r       <= 1'b1;
      samp1_r       <= 1'b1;
      par_bit_r     <= 1'b0;
      rx_data_r     <= '0;
      rx_valid_r    <= 1'b0;
      err_frame_r   <= 1'b0;
      err_parity_r  <= 1'b0;
      err_overrun_r <= 1'b0;
    end else begin
      err_frame_r   <= 1'b0;
      err_parity_r  <= 1'b0;
      err_overrun_r <= 1'b0;
      if (accept_s) begin
        rx_valid_r <= 1'b0;
      end
      // tick index 0 marks a bit boundary; the start edge counts as index 0
      if ((state_r != ST_IDLE) && tick_s) begin
        tick_cnt_r <= (tick_cnt_r == TW'(OVERSAMPLE - 1)) ? '0 : tick_cnt_r + 1'b1;
        if (tick_cnt_r == TW'(OVERSAMPLE / 2 - 1)) samp0_r <= sync2_r;
        if (tick_cnt_r == TW'(OVERSAMPLE / 2))     samp1_r <= sync2_r;
      end
      case (state_r)
        ST_IDLE: begin
          if (fall_s) begin
            state_r    <= ST_START;
            tick_cnt_r <= TW'(1);
            bit_cnt_r  <= '0;
          end
        end
        ST_START: begin
          if (decide_s && maj_s) begin
            state_r <= ST_IDLE;  // glitch, not a real start bit
          end else if (tick_s && (tick_cnt_r == TW'(OVERSAMPLE - 1))) begin
            state_r <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (decide_s) begin
            shift_r <= {maj_s, shift_r[DATA_BITS-1:1]};
            if (bit_cnt_r == BW'(DATA_BITS - 1)) begin
              bit_cnt_r <= '0;
              state_r   <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt_r <= bit_cnt_r + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (decide_s) begin
            par_bit_r <= maj_s;
            state_r   <= ST_STOP;
          end
        end
        ST_STOP: begin
          // re-arm mid stop bit so back-to-back frames are caught
          if (decide_s) begin
            state_r <= ST_IDLE;
            if (!maj_s) begin
              err_frame_r <= 1'b1;
            end else if (par_bad_s) begin
              err_parity_r <= 1'b1;
            end else if (rx_valid_r && !rx_ready) begin
              err_overrun_r <= 1'b1;
            end else begin
              rx_data_r  <= shift_r;
              rx_valid_r <= 1'b1;
            end
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign rx_data     = rx_data_r;
  assign rx_valid    = rx_valid_r;
  assign err_frame   = err_frame_r;
  assign err_parity  = err_parity_r;
  assign err_overrun = err_overrun_r;

endmodule

// File: tb/tb_uart_rx_param.sv
`timescale 1ns/1ps
module tb_uart_rx_param;

  localparam real TCLK = 625.0;       // 1.6 MHz
  localparam int  CLKF = 1_600_000;
  localparam int  K_DATA = 0, K_FRAME = 1, K_PARITY = 2, K_OVERRUN = 3;

  logic       sysclk = 1'b0;
  logic       reset;
  logic [2:0] line;
  logic [2:0] ready;
  logic [2:0] vld, ef, ep, eo;
  logic [7:0] d0_data, d1_data;
  logic [6:0] d2_data;
  logic [8:0] dat [3];

  typedef struct {
    int         dut;
    int         kind;
    logic [8:0] data;
    longint     t_exp;
  } exp_t;

  exp_t       expq[$];
  logic       model_held [3];
  logic       prev_v [3];
  logic [8:0] prev_d [3];
  logic [8:0] last_load [3];
  int         n_load [3], n_efr [3], n_epa [3], n_eov [3];
  int         n_checks = 0, n_fail = 0;

  always #(TCLK / 2.0) sysclk = ~sysclk;

  // DUT0: 8N1, DUT1: 8E1 (both DIV=10); DUT2: 7O1 at 12000 baud, oversample 8
  uart_rx_param #(.CLK_FREQ(CLKF), .BAUD(10_000), .DATA_BITS(8), .PARITY(0), .OVERSAMPLE(16)) dut0 (
    .sysclk(sysclk), .reset(reset), .UART_RX(line[0]), .rx_data(d0_data), .rx_valid(vld[0]),
    .rx_ready(ready[0]), .err_frame(ef[0]), .err_parity(ep[0]), .err_overrun(eo[0]));
  uart_rx_param #(.CLK_FREQ(CLKF), .BAUD(10_000), .DATA_BITS(8), .PARITY(2), .OVERSAMPLE(16)) dut1 (
    .sysclk(sysclk), .reset(reset), .UART_RX(line[1]), .rx_data(d1_data), .rx_valid(vld[1]),
    .rx_ready(ready[1]), .err_frame(ef[1]), .err_parity(ep[1]), .err_overrun(eo[1]));
  uart_rx_param #(.CLK_FREQ(CLKF), .BAUD(12_000), .DATA_BITS(7), .PARITY(1), .OVERSAMPLE(8)) dut2 (
    .sysclk(sysclk), .reset(reset), .UART_RX(line[2]), .rx_data(d2_data), .rx_valid(vld[2]),
    .rx_ready(ready[2]), .err_frame(ef[2]), .err_parity(ep[2]), .err_overrun(eo[2]));

  assign dat[0] = {1'b0, d0_data};
  assign dat[1] = {1'b0, d1_data};
  assign dat[2] = {2'b00, d2_data};

  function automatic int cfg_db(input int d);   return (d == 2) ? 7 : 8;         endfunction
  function automatic int cfg_os(input int d);   return (d == 2) ? 8 : 16;        endfunction
  function automatic int cfg_baud(input int d); return (d == 2) ? 12000 : 10000; endfunction
  function automatic int cfg_par(input int d);  return (d == 0) ? 0 : ((d == 1) ? 2 : 1); endfunction
  // nearest-integer clocks per oversampling tick
  function automatic int cfg_div(input int d);
    int den;
    den = cfg_baud(d) * cfg_os(d);
    return (CLKF + den / 2) / den;
  endfunction
  function automatic longint tol(input int d); return longint'((cfg_div(d) + 6) * TCLK); endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic int pending(input int d);
    int n;
    n = 0;
    foreach (expq[i]) if (expq[i].dut == d) n++;
    return n;
  endfunction

  // drive one frame and record what the receiver must report for it
  task automatic send_frame(input int d, input logic [8:0] data, input logic par, input logic stop);
    int   nb, hp, ones;
    real  bit_ns;
    exp_t e;
    nb     = cfg_db(d);
    hp     = (cfg_par(d) != 0) ? 1 : 0;
    bit_ns = 1.0e9 / cfg_baud(d);
    ones   = 0;
    for (int i = 0; i < nb; i++) ones += int'(data[i]);
    e.dut  = d;
    e.data = data;
    if (!stop) e.kind = K_FRAME;
    else if (cfg_par(d) == 1 && ((ones + int'(par)) % 2) != 1) e.kind = K_PARITY;
    else if (cfg_par(d) == 2 && ((ones + int'(par)) % 2) != 0) e.kind = K_PARITY;
    else if (model_held[d]) e.kind = K_OVERRUN;
    else begin
      e.kind        = K_DATA;
      model_held[d] = ~ready[d];
    end
    line[d] = 1'b0;
    e.t_exp = longint'($realtime) +
              longint'(((1 + nb + hp) * cfg_os(d) + cfg_os(d) / 2 + 1) * cfg_div(d) * TCLK);
    expq.push_back(e);
    #(bit_ns);
    for (int i = 0; i < nb; i++) begin
      line[d] = data[i];
      #(bit_ns);
    end
    if (hp != 0) begin
      line[d] = par;
      #(bit_ns);
    end
    line[d] = stop;
    #(bit_ns);
    line[d] = 1'b1;
  endtask

  task automatic drain(input int d);
    int budget;
    budget = 0;
    while (pending(d) != 0 && budget < 4000) begin
      @(posedge sysclk);
      budget++;
    end
    if (pending(d) != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout dut%0d: %0d events outstanding, required 0", d, pending(d));
    end
  endtask

  task automatic match_event(input int d, input int kind, input logic [8:0] data);
    int     idx;
    exp_t   e;
    longint dt;
    idx = -1;
    foreach (expq[i]) if (idx < 0 && expq[i].dut == d) idx = i;
    if (idx < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event dut%0d: got kind %0d data 0x%0h, required no event", d, kind, data);
    end else begin
      e = expq[idx];
      expq.delete(idx);
      check($sformatf("event_kind dut%0d", d), 32'(kind), 32'(e.kind));
      if (kind == K_DATA) check($sformatf("event_data dut%0d", d), 32'(data), 32'(e.data));
      dt = longint'($realtime) - e.t_exp;
      n_checks++;
      if (dt > tol(d) || dt < -tol(d)) begin
        n_fail++;
        $display("FAIL event_time dut%0d: at %0d ns, required %0d +/- %0d ns", d,
                 longint'($realtime), e.t_exp, tol(d));
      end
    end
  endtask

  // per-cycle comparison of all three receivers against the expectation queue
  initial begin
    foreach (prev_v[d]) begin
      prev_v[d] = 1'b0; prev_d[d] = '0; last_load[d] = '0;
      n_load[d] = 0; n_efr[d] = 0; n_epa[d] = 0; n_eov[d] = 0;
    end
    forever begin
      @(posedge sysclk);
      #1;
      for (int d = 0; d < 3; d++) begin
        if (!reset) begin
          prev_v[d] = 1'b0;
        end else begin
          logic load;
          int   nev, kind;
          load = vld[d] && (!prev_v[d] || ready[d]);
          if (prev_v[d] && !ready[d]) begin
            check($sformatf("hold_valid dut%0d", d), 32'(vld[d]), 32'd1);
            check($sformatf("hold_data dut%0d", d), 32'(dat[d]), 32'(prev_d[d]));
          end
          nev = int'(ef[d]) + int'(ep[d]) + int'(eo[d]) + int'(load);
          if (nev > 1) begin
            n_checks++;
            n_fail++;
            $display("FAIL multi_event dut%0d: %0d simultaneous events, required at most 1", d, nev);
          end else if (nev == 1) begin
            kind = ef[d] ? K_FRAME : (ep[d] ? K_PARITY : (eo[d] ? K_OVERRUN : K_DATA));
            match_event(d, kind, dat[d]);
            if (ef[d]) n_efr[d]++;
            if (ep[d]) n_epa[d]++;
            if (eo[d]) n_eov[d]++;
            if (load) begin
              last_load[d] = dat[d];
              n_load[d]++;
            end
          end
          for (int i = 0; i < expq.size(); i++) begin
            if (expq[i].dut == d && longint'($realtime) > expq[i].t_exp + tol(d)) begin
              n_checks++;
              n_fail++;
              $display("FAIL missing_event dut%0d: kind %0d never seen, required by %0d ns",
                       d, expq[i].kind, expq[i].t_exp);
              expq.delete(i);
              break;
            end
          end
          prev_v[d] = vld[d];
          prev_d[d] = dat[d];
        end
      end
    end
  end

  initial begin
    int base;
    reset = 1'b0;
    line  = 3'b111;
    ready = 3'b111;
    foreach (model_held[d]) model_held[d] = 1'b0;
    repeat (5) @(posedge sysclk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset_data dut%0d", d), 32'(dat[d]), 32'd0);
      check($sformatf("reset_valid dut%0d", d), 32'(vld[d]), 32'd0);
      check($sformatf("reset_errs dut%0d", d), 32'({ef[d], ep[d], eo[d]}), 32'd0);
    end
    @(negedge sysclk);
    reset = 1'b1;
    repeat (20) @(posedge sysclk);

    // back-to-back 0x55, 0xA3 on 8N1
    send_frame(0, 9'h055, 1'b0, 1'b1);
    check("b2b_first", 32'(last_load[0]), 32'h55);
    send_frame(0, 9'h0A3, 1'b0, 1'b1);
    drain(0);
    check("b2b_second", 32'(last_load[0]), 32'hA3);
    check("b2b_count", 32'(n_load[0]), 32'd2);

    // short low glitch is rejected, then a real frame
    #(20000.0);
    base = n_load[0];
    line[0] = 1'b0;
    #(1500.0);
    line[0] = 1'b1;
    #(300000.0);
    check("glitch_no_load", 32'(n_load[0]), 32'(base));
    check("glitch_no_err", 32'(n_efr[0] + n_epa[0] + n_eov[0]), 32'd0);
    send_frame(0, 9'h00F, 1'b0, 1'b1);
    drain(0);
    check("after_glitch", 32'(last_load[0]), 32'h0F);

    // even parity: 0x07 has three ones, so the parity bit must be 1
    send_frame(1, 9'h007, 1'b0, 1'b1);
    drain(1);
    check("even_par_err", 32'(n_epa[1]), 32'd1);
    check("even_par_noload", 32'(n_load[1]), 32'd0);
    send_frame(1, 9'h007, 1'b1, 1'b1);
    drain(1);
    check("even_par_ok", 32'(last_load[1]), 32'h07);

    // stop bit low
    send_frame(0, 9'h0FF, 1'b0, 1'b0);
    #(100000.0);
    drain(0);
    check("frame_err", 32'(n_efr[0]), 32'd1);
    check("frame_noload", 32'(last_load[0]), 32'h0F);

    // 7O1: 0x3A has four ones, so odd parity bit is 1
    send_frame(2, 9'h03A, 1'b1, 1'b1);
    drain(2);
    check("odd_par_ok", 32'(last_load[2]), 32'h3A);
    send_frame(2, 9'h03A, 1'b0, 1'b1);
    drain(2);
    check("odd_par_err", 32'(n_epa[2]), 32'd1);

    // backpressure: second word overruns, first is held
    @(negedge sysclk);
    ready[0] = 1'b0;
    send_frame(0, 9'h011, 1'b0, 1'b1);
    send_frame(0, 9'h022, 1'b0, 1'b1);
    drain(0);
    check("ovr_pulse", 32'(n_eov[0]), 32'd1);
    check("ovr_held_data", 32'(dat[0]), 32'h11);
    check("ovr_held_valid", 32'(vld[0]), 32'd1);

    // asynchronous reset in the middle of a third frame
    fork
      send_frame(0, 9'h044, 1'b0, 1'b1);
      begin
        #(450000.0);
        reset = 1'b0;
        #1;
        check("areset_data", 32'(dat[0]), 32'd0);
        check("areset_valid", 32'(vld[0]), 32'd0);
        check("areset_errs", 32'({ef[0], ep[0], eo[0]}), 32'd0);
        expq.delete();
        foreach (model_held[d]) model_held[d] = 1'b0;
      end
    join
    #(100000.0);
    @(negedge sysclk);
    reset    = 1'b1;
    ready[0] = 1'b1;
    repeat (20) @(posedge sysclk);
    send_frame(0, 9'h033, 1'b0, 1'b1);
    drain(0);
    check("post_reset", 32'(last_load[0]), 32'h33);
    repeat (50) @(posedge sysclk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver that replaces the fixed 9600-baud, 8N1 receive path feeding the CPU's `UART_RX` pin. It provides:

- configurable clock frequency, baud rate, data width, parity and oversampling;
- majority-vote sampling and false-start rejection;
- framing, parity and overrun error reporting;
- a valid/ready output holding register, so CPU peripheral logic can consume bytes at its own pace.

## Interface
- `CLK_FREQ`, 100_000_000, sysclk frequency in Hz
- `BAUD`, 9600, line bit rate
- `DATA_BITS`, 8, data bits per frame, 5..9, LSB first
- `PARITY`, 0, parity mode: 0 none, 1 odd, 2 even
- `OVERSAMPLE`, 16, ticks per bit period, even, ≥ 8
- `sysclk`  in  1  system clock; all logic is on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `UART_RX`  in  1  serial line, idles high; asynchronous to sysclk
- `rx_data`  out  DATA_BITS  received word; stable while `rx_valid`=1
- `rx_valid`  out  1  word available; held until accepted
- `rx_ready`  in  1  consumer accepts the word when `rx_valid` & `rx_ready`
- `err_frame`  out  1  one-cycle pulse: stop bit sampled low
- `err_parity`  out  1  one-cycle pulse: parity mismatch
- `err_overrun`  out  1  one-cycle pulse: frame completed while `rx_valid`=1 and not accepted

## Operation
- Input synchronisation:
  - `UART_RX` passes through a 2-flop synchroniser, reset to 1.
  - A third registered copy is used for falling-edge detection.
- Tick generation:
  - A tick fires every `DIV` = round(`CLK_FREQ` / (`BAUD`·`OVERSAMPLE`)) sysclk cycles.
  - The divider is restarted at start-edge detection.
  - Elaboration fails if `DIV` < 2.
- Sampling:
  - Each bit is resolved by a 2-of-3 majority of the synchronised line.
  - The three samples are taken at ticks `OVERSAMPLE`/2−1, `OVERSAMPLE`/2 and `OVERSAMPLE`/2+1 of that bit.
  - The bit value is decided at the third sample.
- State machine:
  - IDLE → START on a synchronised falling edge.
  - START: if the majority is 1 it is a false start → IDLE with no error; otherwise advance to DATA at the end of the bit period.
  - DATA: shift `DATA_BITS` bits in LSB first → PARITY if `PARITY`≠0, else → STOP.
  - PARITY: compare the received bit with the computed odd/even parity → STOP.
  - STOP: on the stop-bit decision → IDLE immediately. The receiver re-arms mid-stop-bit, so back-to-back frames are supported.
- Frame completion, evaluated at the stop decision in this priority order:
  - Stop = 0: `err_frame` pulses; the word is discarded.
  - Else parity bad: `err_parity` pulses; the word is discarded.
  - Else `rx_valid`=1 and not accepted this cycle: `err_overrun` pulses; the new word is dropped and the held word is unchanged.
  - Else: `rx_data` loads and `rx_valid` sets.
- Output handshake:
  - `rx_valid` clears on the cycle after `rx_valid` & `rx_ready`.
  - Acceptance and a new load on the same edge is legal: the new word loads and `rx_valid` stays 1 with no overrun.
- Reset (asserted asynchronously at any time, including mid-frame):
  - State returns to IDLE; divider and counters clear.
  - `rx_data`=0, `rx_valid`=0, all error pulses 0.
  - The partial frame is lost; the first falling edge after reset release starts a new frame.

## Timing
- Synchroniser latency is 2 cycles; edge detect adds 1 cycle.
- `rx_valid` and the error pulses assert on the edge after the stop-bit third sample, i.e. ~(1 + `DATA_BITS` + (`PARITY`≠0))·`OVERSAMPLE` + `OVERSAMPLE`/2 + 1 ticks after the start edge, ±1 tick.
- Each error pulse is exactly 1 sysclk cycle wide; at most one error pulses per frame.
- With no backpressure, sustained throughput is one word per frame time.
- Baud tolerance is ±3% at `OVERSAMPLE`=16.

## Structure
- Package `uart_pkg` holds:
  - the state enum (`ST_IDLE`, `ST_START`, `ST_DATA`, `ST_PARITY`, `ST_STOP`);
  - parity constants `PAR_NONE`/`PAR_ODD`/`PAR_EVEN`;
  - a constant function computing `DIV` with rounding.
  - A future `uart_tx_param` will share this package.
- Sub-module `uart_baud_tick` (parameter `DIV`; inputs `sysclk`, `reset`, `restart`; output `tick`) is the natural split.
- Counter widths: divider is $clog2(`DIV`); the tick-in-bit counter is $clog2(`OVERSAMPLE`); the bit counter is $clog2(`DATA_BITS`+1).

## Test plan
Benches use `CLK_FREQ`=1_600_000, `BAUD`=10_000, `OVERSAMPLE`=16 (`DIV`=10) unless noted.
- 8N1, send 0x55 then 0xA3 back-to-back, `rx_ready` held 1 → `rx_valid` pulses twice with 0x55 then 0xA3; no errors.
- 100 MHz / 9600 defaults, send 0x3A at a 104166 ns bit time → `rx_data`=0x3A, `rx_valid`=1 about 0.99 ms after the start edge.
- 1.5 µs low glitch on idle line → no `rx_valid`, no error; the next real frame 0x0F is received correctly.
- Even parity, send 0x07 with parity bit 0 → one `err_parity` pulse, `rx_valid` stays 0. Then 0x07 with parity bit 1 → `rx_data`=0x07.
- 8N1, 0xFF with stop bit driven 0 → `err_frame` pulse, no `rx_valid`.
- `rx_ready`=0, send 0x11 then 0x22 → `rx_data`=0x11 is held and `err_overrun` pulses once. Assert `reset` low mid-way through a third frame → all outputs return to 0 asynchronously, and a frame 0x33 sent after release is received.
